// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID pipeline register, field and immediate
// decode, and a 32x32 register file with write-first read bypass.
module id_stage #(
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_instruction,
  input  logic [31:0]       if_pc_plus4,
  input  logic              if_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [31:0]       id_instruction,
  output logic [31:0]       id_pc_plus4,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [31:0]       imm_sext,
  output logic [31:0]       imm_zext,
  output logic [31:0]       jump_target,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  logic [DATA_W-1:0] regs [32];
  logic              wb_hit;

  assign wb_hit = wb_we && (wb_addr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instruction <= NOP_WORD;
      id_pc_plus4    <= '0;
      id_valid       <= 1'b0;
    end else if (flush) begin
      id_instruction <= NOP_WORD;
      id_pc_plus4    <= '0;
      id_valid       <= 1'b0;
    end else if (!stall) begin
      id_instruction <= if_instruction;
      id_pc_plus4    <= if_pc_plus4;
      id_valid       <= if_valid;
    end
  end

  // Write-back is independent of stall/flush so a retiring instruction is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign opcode      = id_instruction[31:26];
  assign rs          = id_instruction[25:21];
  assign rt          = id_instruction[20:16];
  assign rd          = id_instruction[15:11];
  assign shamt       = id_instruction[10:6];
  assign funct       = id_instruction[5:0];
  assign imm_sext    = {{16{id_instruction[15]}}, id_instruction[15:0]};
  assign imm_zext    = {16'h0000, id_instruction[15:0]};
  assign jump_target = {id_pc_plus4[31:28], id_instruction[25:0], 2'b00};

  always_comb begin
    rs_data = '0;
    if (rs != 5'd0) begin
      if (wb_hit && (wb_addr == rs)) rs_data = wb_data;
      else                           rs_data = regs[rs];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt != 5'd0) begin
      if (wb_hit && (wb_addr == rt)) rt_data = wb_data;
      else                           rt_data = regs[rt];
    end
  end

endmodule
